// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore-style FSM that steps through fetch,
// decode and per-class execute states and drives the datapath selects and
// enables. Any unsupported encoding parks the FSM in ILLEGAL until reset.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inStr,
  output logic        adrSrc,
  output logic        IRWrite,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluControl,
  output logic [2:0]  immSrc,
  output logic        pcUpdate,
  output logic        branch1,
  output logic        branch2,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
    S_LUI, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state, next_state;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       f7b;
  logic       unused_inst_bits;

  assign op     = inStr[6:0];
  assign funct3 = inStr[14:12];
  assign f7b    = inStr[30];
  assign unused_inst_bits = ^{inStr[31], inStr[29:15], inStr[11:7]};

  // State register; reset always returns to FETCH, which also clears illegal.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state and output decode; reset forces every output low combinationally.
  always_comb begin
    next_state = state;
    adrSrc     = 1'b0;
    IRWrite    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = 2'd0;
    aluSrcA    = 2'd0;
    aluSrcB    = 2'd0;
    aluControl = ALU_ADD;
    immSrc     = 3'b000;
    pcUpdate   = 1'b0;
    branch1    = 1'b0;
    branch2    = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        aluSrcB   = 2'd2;
        resultSrc = 2'd1;
        pcUpdate  = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'd1;
        aluSrcB = 2'd1;
        immSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
          OP_R:              next_state = S_EXEC_R;
          OP_I:              next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        aluSrcA = 2'd2;
        aluSrcB = 2'd1;
        // op[5] separates store (0100011) from load (0000011)
        immSrc  = op[5] ? 3'b001 : 3'b000;
        next_state = op[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adrSrc = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        resultSrc = 2'd2;
        regWrite  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC_R: begin
        aluSrcA = 2'd2;
        next_state = S_ALU_WB;
        case ({funct3, f7b})
          4'b000_0: aluControl = ALU_ADD;
          4'b000_1: aluControl = ALU_SUB;
          4'b111_0: aluControl = ALU_AND;
          4'b110_0: aluControl = ALU_OR;
          4'b010_0: aluControl = ALU_SLT;
          default:  next_state = S_ILLEGAL;
        endcase
      end
      S_EXEC_I: begin
        aluSrcA = 2'd2;
        aluSrcB = 2'd1;
        next_state = S_ALU_WB;
        case (funct3)
          3'b000:  aluControl = ALU_ADD;
          3'b111:  aluControl = ALU_AND;
          3'b110:  aluControl = ALU_OR;
          3'b010:  aluControl = ALU_SLT;
          default: next_state = S_ILLEGAL;
        endcase
      end
      S_ALU_WB: begin
        regWrite = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = 2'd2;
        next_state = S_FETCH;
        case (funct3)
          3'b000, 3'b001: begin
            aluControl = ALU_SUB;
            branch1    = 1'b1;
          end
          3'b100, 3'b101: begin
            aluControl = ALU_SLT;
            branch2    = 1'b1;
          end
          default: next_state = S_ILLEGAL;
        endcase
      end
      S_JAL, S_JALR_LINK: begin
        aluSrcA  = 2'd1;
        aluSrcB  = 2'd2;
        pcUpdate = 1'b1;
        next_state = S_ALU_WB;
      end
      // First JALR visit computes rs1+imm into the ALU-out register; the
      // second visit loads it into PC while the ALU produces oldPC+4 for rd.
      S_JALR: begin
        aluSrcA = 2'd2;
        aluSrcB = 2'd1;
        next_state = (funct3 == 3'b000) ? S_JALR_LINK : S_ILLEGAL;
      end
      S_LUI: begin
        immSrc    = 3'b100;
        resultSrc = 2'd3;
        regWrite  = 1'b1;
        next_state = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    if (rst) begin
      adrSrc     = 1'b0;
      IRWrite    = 1'b0;
      memWrite   = 1'b0;
      regWrite   = 1'b0;
      resultSrc  = 2'd0;
      aluSrcA    = 2'd0;
      aluSrcB    = 2'd0;
      aluControl = ALU_ADD;
      immSrc     = 3'b000;
      pcUpdate   = 1'b0;
      branch1    = 1'b0;
      branch2    = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction tables of expected
// per-cycle output vectors, queued as a scoreboard and checked each cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inStr;
  logic        adrSrc, IRWrite, memWrite, regWrite;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB;
  logic [2:0]  aluControl, immSrc;
  logic        pcUpdate, branch1, branch2, illegal;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .inStr(inStr),
    .adrSrc(adrSrc), .IRWrite(IRWrite), .memWrite(memWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .immSrc(immSrc), .pcUpdate(pcUpdate),
    .branch1(branch1), .branch2(branch2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {adrSrc,IRWrite,memWrite,regWrite,resultSrc,aluSrcA,aluSrcB,aluControl,immSrc,pcUpdate,branch1,branch2,illegal}
  function automatic logic [19:0] o(input logic ad, input logic ir, input logic mw,
      input logic rw, input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
      input logic [2:0] alu, input logic [2:0] imm, input logic pc, input logic b1,
      input logic b2, input logic il);
    return {ad, ir, mw, rw, rs, a, b, alu, imm, pc, b1, b2, il};
  endfunction

  logic [19:0] e_fetch, e_memrd, e_memwb, e_memwr, e_aluwb, e_jal, e_jalr1, e_lui, e_ill, e_zero;

  typedef struct packed {
    logic [31:0]      instr;
    logic [2:0]       n;
    logic [4:0][19:0] exp;
  } vec_t;

  vec_t        tbl [18];
  logic [19:0] sb [$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  function automatic logic [19:0] actual();
    return {adrSrc, IRWrite, memWrite, regWrite, resultSrc, aluSrcA, aluSrcB,
            aluControl, immSrc, pcUpdate, branch1, branch2, illegal};
  endfunction

  // Compare one cycle at the falling edge against the scoreboard head, then
  // advance to just after the next rising edge.
  task automatic step(input string name);
    logic [19:0] want;
    @(negedge clk);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", name, actual());
    end else begin
      want = sb.pop_front();
      if (actual() !== want) begin
        fails++;
        $display("FAIL %s: got %h want %h", name, actual(), want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] n,
      input logic [19:0] x2, input logic [19:0] x3, input logic [19:0] x4,
      input logic [19:0] x5);
    vec_t v;
    v.instr = i;
    v.n = n;
    v.exp[0] = o(0,1,0,0,2'd1,2'd0,2'd2,3'b000,3'b000,1,0,0,0);
    v.exp[1] = x2;
    v.exp[2] = x3;
    v.exp[3] = x4;
    v.exp[4] = x5;
    return v;
  endfunction

  function automatic logic [19:0] dec(input logic [2:0] imm);
    return o(0,0,0,0,2'd0,2'd1,2'd1,3'b000,imm,0,0,0,0);
  endfunction
  function automatic logic [19:0] exr(input logic [2:0] alu);
    return o(0,0,0,0,2'd0,2'd2,2'd0,alu,3'b000,0,0,0,0);
  endfunction
  function automatic logic [19:0] exi(input logic [2:0] alu);
    return o(0,0,0,0,2'd0,2'd2,2'd1,alu,3'b000,0,0,0,0);
  endfunction
  function automatic logic [19:0] madr(input logic [2:0] imm);
    return o(0,0,0,0,2'd0,2'd2,2'd1,3'b000,imm,0,0,0,0);
  endfunction
  function automatic logic [19:0] br(input logic [2:0] alu, input logic b1, input logic b2);
    return o(0,0,0,0,2'd0,2'd2,2'd0,alu,3'b000,0,b1,b2,0);
  endfunction

  initial begin
    e_fetch = o(0,1,0,0,2'd1,2'd0,2'd2,3'b000,3'b000,1,0,0,0);
    e_memrd = o(1,0,0,0,2'd0,2'd0,2'd0,3'b000,3'b000,0,0,0,0);
    e_memwb = o(0,0,0,1,2'd2,2'd0,2'd0,3'b000,3'b000,0,0,0,0);
    e_memwr = o(1,0,1,0,2'd0,2'd0,2'd0,3'b000,3'b000,0,0,0,0);
    e_aluwb = o(0,0,0,1,2'd0,2'd0,2'd0,3'b000,3'b000,0,0,0,0);
    e_jal   = o(0,0,0,0,2'd0,2'd1,2'd2,3'b000,3'b000,1,0,0,0);
    e_jalr1 = o(0,0,0,0,2'd0,2'd2,2'd1,3'b000,3'b000,0,0,0,0);
    e_lui   = o(0,0,0,1,2'd3,2'd0,2'd0,3'b000,3'b100,0,0,0,0);
    e_ill   = o(0,0,0,0,2'd0,2'd0,2'd0,3'b000,3'b000,0,0,0,1);
    e_zero  = '0;

    tbl[0]  = mk(32'h002081B3, 3'd4, dec(3'b010), exr(3'b000), e_aluwb, '0);      // add
    tbl[1]  = mk(32'h402081B3, 3'd4, dec(3'b010), exr(3'b001), e_aluwb, '0);      // sub
    tbl[2]  = mk(32'h0020F1B3, 3'd4, dec(3'b010), exr(3'b010), e_aluwb, '0);      // and
    tbl[3]  = mk(32'h0020E1B3, 3'd4, dec(3'b010), exr(3'b011), e_aluwb, '0);      // or
    tbl[4]  = mk(32'h0020A1B3, 3'd4, dec(3'b010), exr(3'b101), e_aluwb, '0);      // slt
    tbl[5]  = mk(32'h00508093, 3'd4, dec(3'b010), exi(3'b000), e_aluwb, '0);      // addi
    tbl[6]  = mk(32'h0050F093, 3'd4, dec(3'b010), exi(3'b010), e_aluwb, '0);      // andi
    tbl[7]  = mk(32'h0050E093, 3'd4, dec(3'b010), exi(3'b011), e_aluwb, '0);      // ori
    tbl[8]  = mk(32'h0050A093, 3'd4, dec(3'b010), exi(3'b101), e_aluwb, '0);      // slti
    tbl[9]  = mk(32'h0080A283, 3'd5, dec(3'b010), madr(3'b000), e_memrd, e_memwb); // lw
    tbl[10] = mk(32'h0050A623, 3'd4, dec(3'b010), madr(3'b001), e_memwr, '0);     // sw
    tbl[11] = mk(32'h00208463, 3'd3, dec(3'b010), br(3'b001,1,0), '0, '0);        // beq
    tbl[12] = mk(32'h00209463, 3'd3, dec(3'b010), br(3'b001,1,0), '0, '0);        // bne
    tbl[13] = mk(32'h0020C463, 3'd3, dec(3'b010), br(3'b101,0,1), '0, '0);        // blt
    tbl[14] = mk(32'h0020D463, 3'd3, dec(3'b010), br(3'b101,0,1), '0, '0);        // bge
    tbl[15] = mk(32'h010000EF, 3'd4, dec(3'b011), e_jal, e_aluwb, '0);            // jal
    tbl[16] = mk(32'h000080E7, 3'd5, dec(3'b010), e_jalr1, e_jal, e_aluwb);       // jalr
    tbl[17] = mk(32'h000012B7, 3'd3, dec(3'b010), e_lui, '0, '0);                 // lui

    // Reset: outputs forced low while rst is high.
    rst = 1'b1;
    inStr = 32'h002081B3;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(e_zero);
      step("reset_outputs");
    end
    rst = 1'b0;

    // Table-driven legal instructions, issued back to back.
    for (int t = 0; t < 18; t++) begin
      inStr = tbl[t].instr;
      for (int c = 0; c < int'(tbl[t].n); c++) sb.push_back(tbl[t].exp[c]);
      for (int c = 0; c < int'(tbl[t].n); c++) step($sformatf("instr%0d_cyc%0d", t, c + 1));
    end
    // Boundary: after the last instruction the FSM is back in FETCH.
    sb.push_back(e_fetch);
    step("return_to_fetch");

    // Unknown opcode: illegal from cycle 3, held for 22 cycles.
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    inStr = 32'h00000000;
    sb.push_back(e_fetch);
    sb.push_back(dec(3'b010));
    for (int i = 0; i < 22; i++) sb.push_back(e_ill);
    for (int i = 0; i < 24; i++) step("illegal_opcode_sticky");

    // Reset pulse clears illegal and restarts at FETCH.
    rst = 1'b1;
    sb.push_back(e_zero);
    step("illegal_reset");
    rst = 1'b0;
    inStr = 32'h0050A623;
    sb.push_back(e_fetch);
    sb.push_back(dec(3'b010));
    sb.push_back(madr(3'b001));
    for (int i = 0; i < 3; i++) step("sw_before_reset");
    // Reset asserted in the MEM_WRITE cycle: memWrite must drop immediately.
    rst = 1'b1;
    sb.push_back(e_zero);
    step("sw_reset_midwrite");
    rst = 1'b0;
    sb.push_back(e_fetch);
    step("fetch_after_reset");

    // Unsupported R funct3 (sll) goes illegal after EXEC_R.
    inStr = 32'h002091B3;
    sb.push_back(dec(3'b010));
    sb.push_back(exr(3'b000));
    sb.push_back(e_ill);
    for (int i = 0; i < 3; i++) step("r_bad_funct");

    // Unsupported branch funct3: no strobe, then illegal.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    inStr = 32'h0020A463;
    sb.push_back(e_fetch);
    sb.push_back(dec(3'b010));
    sb.push_back(br(3'b000,0,0));
    sb.push_back(e_ill);
    for (int i = 0; i < 4; i++) step("branch_bad_funct");

    // JALR with nonzero funct3 goes illegal after the first visit.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    inStr = 32'h000090E7;
    sb.push_back(e_fetch);
    sb.push_back(dec(3'b010));
    sb.push_back(e_jalr1);
    sb.push_back(e_ill);
    for (int i = 0; i < 4; i++) step("jalr_bad_funct");

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inStr  input  32  instruction register contents; op=inStr[6:0], funct3=inStr[14:12], f7b=inStr[30]; sampled from DECODE onward.
REQ-005 adrSrc  output  1  memory address select: 0=PC, 1=result.
REQ-006 IRWrite  output  1  loads instruction and old-PC register.
REQ-007 memWrite  output  1  data memory write enable.
REQ-008 regWrite  output  1  register file write enable.
REQ-009 resultSrc  output  2  result select: 0=ALU-out register, 1=ALU result, 2=memory-data register, 3=immExt.
REQ-010 aluSrcA  output  2  ALU A select: 0=PC, 1=oldPC, 2=rs1 register.
REQ-011 aluSrcB  output  2  ALU B select: 0=rs2 register, 1=immExt, 2=constant 4.
REQ-012 aluControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 immSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-014 pcUpdate  output  1  unconditional PC load of result.
REQ-015 branch1  output  1  conditional PC load on zero^funct3[0] (beq/bne).
REQ-016 branch2  output  1  conditional PC load on slt^funct3[0] (blt/bge).
REQ-017 illegal  output  1  unsupported instruction decoded; sticky until rst.

Function
REQ-018 Moore FSM; states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, ILLEGAL.
REQ-019 Any output not listed for a state SHALL be 0.
REQ-020 FETCH: adrSrc=0, IRWrite=1, aluSrcA=0, aluSrcB=2, add, resultSrc=1, pcUpdate=1; next DECODE.
REQ-021 DECODE: aluSrcA=1, aluSrcB=1, add, immSrc=011 if op=1101111 else 010; next by op: 0000011/0100011 MEM_ADR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, other ILLEGAL.
REQ-022 MEM_ADR: aluSrcA=2, aluSrcB=1, add, immSrc=000 (lw) or 001 (sw); next MEM_READ if lw, MEM_WRITE if sw.
REQ-023 MEM_READ: adrSrc=1, resultSrc=0; next MEM_WB. MEM_WB: resultSrc=2, regWrite=1; next FETCH.
REQ-024 MEM_WRITE: adrSrc=1, resultSrc=0, memWrite=1; next FETCH.
REQ-025 EXEC_R: aluSrcA=2, aluSrcB=0; funct3/f7b 000/0 add, 000/1 sub, 111/0 and, 110/0 or, 010/0 slt, else ILLEGAL; next ALU_WB.
REQ-026 EXEC_I: aluSrcA=2, aluSrcB=1, immSrc=000; funct3 000 add, 111 and, 110 or, 010 slt, else ILLEGAL; next ALU_WB.
REQ-027 ALU_WB: resultSrc=0, regWrite=1; next FETCH.
REQ-028 BRANCH: aluSrcA=2, aluSrcB=0, resultSrc=0; funct3 000/001 -> sub, branch1=1; 100/101 -> slt, branch2=1; other funct3 -> ILLEGAL with no branch strobe; next FETCH.
REQ-029 JAL: aluSrcA=1, aluSrcB=2, add, resultSrc=0, pcUpdate=1; next ALU_WB (rd <= oldPC+4).
REQ-030 JALR: two visits; first: aluSrcA=2, aluSrcB=1, immSrc=000, add, next JALR second; second: aluSrcA=1, aluSrcB=2, add, resultSrc=0, pcUpdate=1, next ALU_WB; funct3 != 000 -> ILLEGAL.
REQ-031 LUI: immSrc=100, resultSrc=3, regWrite=1; next FETCH.
REQ-032 ILLEGAL: illegal=1, all enables 0; remains until rst.
REQ-033 Latency: lw 5 cycles, sw/R/I/LUI 3-4 cycles (R/I 4, LUI 3, sw 4), branch 3, jal 4, jalr 5.
REQ-034 At most one of pcUpdate, branch1, branch2 SHALL be 1 in any cycle; memWrite and regWrite never both 1.

Reset
REQ-035 While rst=1, all outputs SHALL be 0 combinationally, including mid-instruction (e.g. memWrite drops in the same cycle).
REQ-036 Rising edge with rst=1 SHALL set state FETCH and clear illegal; first cycle after rst falls is FETCH.

Verification
REQ-037 inStr=0x002081B3 (add x3,x1,x2) -> FETCH,DECODE,EXEC_R(aluControl=000,aluSrcA=2,aluSrcB=0),ALU_WB(regWrite=1); regWrite high exactly 1 cycle.
REQ-038 inStr=0x0080A283 (lw x5,8(x1)) -> 5 cycles; MEM_READ adrSrc=1; MEM_WB resultSrc=2, regWrite=1; memWrite never 1.
REQ-039 inStr=0x0050A623 (sw x5,12(x1)) -> MEM_ADR immSrc=001; memWrite=1 for exactly 1 cycle, adrSrc=1; back to FETCH in cycle 5.
REQ-040 inStr=0x00208463 (beq) -> DECODE immSrc=010; BRANCH aluControl=001, branch1=1, branch2=0; FETCH in cycle 4.
REQ-041 inStr=0x010000EF (jal x1,16) -> DECODE immSrc=011; JAL pcUpdate=1, resultSrc=0; ALU_WB regWrite=1.
REQ-042 inStr=0x00000000 -> illegal=1 from cycle 3 and held 20+ cycles; rst pulse during sw MEM_WRITE -> memWrite=0 that cycle, illegal=0, FETCH after rst.
